pipe_stage_skid: RTL and testbench

- Parametrised successor of the fixed ID/EX pipeline register: one generic pipeline stage with valid/ready handshake and a 2-entry skid buffer.
- Replaces the global hold_flag stall with local backpressure. Adds synchronous flush with bubble insertion and a saturating stall-cycle counter.
- Instantiated between any two core stages (IF/ID, ID/EX, EX/MEM); payload is the concatenated stage bundle (inst, addr, reg/csr fields).

---
 rtl/pipe_stage_skid.sv | 99 +++++++++
 tb/tb_pipe_stage_skid.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage with a 2-entry skid buffer, synchronous
// flush with bubble insertion and a saturating stall-cycle counter.
module pipe_stage_skid #(
    parameter int              DW           = 32,
    parameter logic [DW-1:0]   BUBBLE_VAL   = '0,
    parameter bit              CLEAR_BUBBLE = 1'b1,
    parameter int              CW           = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [DW-1:0] in_data_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] out_data_o,
    input  logic          cnt_clr_i,
    output logic [CW-1:0] stall_cnt_o
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t        state, state_nxt;
    logic [DW-1:0] main_nxt;
    logic [DW-1:0] skid, skid_nxt;
    logic          in_fire, out_fire;

    assign in_fire  = in_valid_i & in_ready_o;
    assign out_fire = out_valid_o & out_ready_i;

    always_comb begin
        state_nxt = state;
        main_nxt  = out_data_o;
        skid_nxt  = skid;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_nxt = ONE;
                    main_nxt  = in_data_i;
                end
            end
            ONE: begin
                if (out_fire && in_fire) begin
                    main_nxt = in_data_i;
                end else if (out_fire) begin
                    state_nxt = EMPTY;
                end else if (in_fire) begin
                    state_nxt = TWO;
                    skid_nxt  = in_data_i;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_nxt = ONE;
                    main_nxt  = skid;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        if (flush_i) begin
            state_nxt = EMPTY;
        end
        // The main register is the output register, so bubbles are written into it.
        if (CLEAR_BUBBLE && state_nxt == EMPTY) begin
            main_nxt = BUBBLE_VAL;
        end
    end

    // Handshake outputs come from the next state so they are plain flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= EMPTY;
            out_data_o  <= BUBBLE_VAL;
            skid        <= '0;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
        end else begin
            state       <= state_nxt;
            out_data_o  <= main_nxt;
            skid        <= skid_nxt;
            out_valid_o <= (state_nxt != EMPTY);
            in_ready_o  <= (state_nxt != TWO);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            stall_cnt_o <= '0;
        end else if (out_valid_o && !out_ready_i && stall_cnt_o != CNT_MAX) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus randomized traffic checked
// every cycle against a queue-based model of the stage.
module tb_pipe_stage_skid;

    localparam int          DW  = 32;
    localparam int          CW  = 4;
    localparam logic [31:0] BUB = 32'h0000_0013;
    localparam int          SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i, cnt_clr_i;
    logic [DW-1:0] in_data_i, out_data_o;
    logic [CW-1:0] stall_cnt_o;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b1;

    // Model: contents of the stage in arrival order, plus the stall count.
    logic [DW-1:0] q[$];
    int            m_cnt  = 0;
    bit            held_v = 1'b0;
    logic [DW-1:0] held_d = '0;

    pipe_stage_skid #(
        .DW(DW), .BUBBLE_VAL(BUB), .CLEAR_BUBBLE(1'b1), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
        .cnt_clr_i(cnt_clr_i), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        bit inf, outf;
        if (!rst) begin
            q.delete();
            m_cnt  = 0;
            held_v = 1'b0;
            return;
        end
        inf    = in_valid_i && (q.size() < 2);
        outf   = (q.size() > 0) && out_ready_i;
        held_v = (q.size() > 0) && !out_ready_i && !flush_i;
        held_d = (q.size() > 0) ? q[0] : BUB;
        if (cnt_clr_i)                                      m_cnt = 0;
        else if (q.size() > 0 && !out_ready_i && m_cnt < SAT) m_cnt++;
        if (outf)    void'(q.pop_front());
        if (inf)     q.push_back(in_data_i);
        if (flush_i) q.delete();
    endtask

    // Commit current inputs to the model, then wait for the next falling edge.
    task automatic cyc();
        model_step();
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("out_valid", {31'b0, out_valid_o}, {31'b0, q.size() > 0});
            chk("in_ready", {31'b0, in_ready_o}, {31'b0, q.size() < 2});
            chk("out_data", out_data_o, (q.size() > 0) ? q[0] : BUB);
            chk("stall_cnt", {28'b0, stall_cnt_o}, m_cnt);
            if (held_v) chk("stable", out_data_o, held_d);
        end
    end

    initial begin
        rst = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        cnt_clr_i = 1'b0; in_data_i = '0;
        @(negedge clk);
        cyc(); cyc();
        chk("rst_valid", {31'b0, out_valid_o}, 32'd0);
        chk("rst_data", out_data_o, 32'h13);
        chk("rst_ready", {31'b0, in_ready_o}, 32'd1);
        chk("rst_cnt", {28'b0, stall_cnt_o}, 32'd0);
        rst = 1'b1;
        cyc(); cyc();
        chk("idle_data", out_data_o, 32'h13);

        // Back-to-back stream with the sink always ready.
        for (int k = 1; k <= 8; k++) begin
            in_valid_i = 1'b1; in_data_i = k; out_ready_i = 1'b1;
            cyc();
            chk("stream_data", out_data_o, k);
            chk("stream_ready", {31'b0, in_ready_o}, 32'd1);
        end
        in_valid_i = 1'b0;
        cyc();
        chk("stream_end_valid", {31'b0, out_valid_o}, 32'd0);
        chk("stream_cnt", {28'b0, stall_cnt_o}, 32'd0);

        // Backpressure fills main and skid; release drains in order.
        cnt_clr_i = 1'b1; in_valid_i = 1'b1; in_data_i = 32'hA; out_ready_i = 1'b0;
        cyc();
        cnt_clr_i = 1'b0;
        chk("bp_first", out_data_o, 32'hA);
        chk("bp_ready1", {31'b0, in_ready_o}, 32'd1);
        in_data_i = 32'hB;
        cyc();
        chk("bp_ready0", {31'b0, in_ready_o}, 32'd0);
        chk("bp_hold", out_data_o, 32'hA);
        in_data_i = 32'hC;
        cyc(); cyc(); cyc();
        chk("bp_cnt", {28'b0, stall_cnt_o}, 32'd4);
        out_ready_i = 1'b1;
        cyc();
        chk("bp_out_b", out_data_o, 32'hB);
        cyc();
        chk("bp_out_c", out_data_o, 32'hC);
        in_valid_i = 1'b0;
        cyc();
        chk("bp_drained", {31'b0, out_valid_o}, 32'd0);
        chk("bp_bubble", out_data_o, 32'h13);

        // Flush with two entries held and a pending input.
        in_valid_i = 1'b1; in_data_i = 32'hE; out_ready_i = 1'b0;
        cyc();
        in_data_i = 32'hF;
        cyc();
        flush_i = 1'b1; in_data_i = 32'hD;
        cyc();
        chk("fl_valid", {31'b0, out_valid_o}, 32'd0);
        chk("fl_ready", {31'b0, in_ready_o}, 32'd1);
        chk("fl_data", out_data_o, 32'h13);
        flush_i = 1'b0; in_valid_i = 1'b0;
        cyc();
        chk("fl_no_d", {31'b0, out_valid_o}, 32'd0);
        // Flush in the same cycle as an accepted input drops that input.
        in_valid_i = 1'b1; in_data_i = 32'h31; out_ready_i = 1'b1;
        cyc();
        flush_i = 1'b1; in_data_i = 32'h32; out_ready_i = 1'b0;
        cyc();
        flush_i = 1'b0; in_valid_i = 1'b0;
        cyc();
        chk("fl_drop_in", {31'b0, out_valid_o}, 32'd0);

        // Saturation, then clear winning over a stall.
        cnt_clr_i = 1'b1; in_valid_i = 1'b1; in_data_i = 32'h55; out_ready_i = 1'b0;
        cyc();
        cnt_clr_i = 1'b0; in_valid_i = 1'b0;
        repeat (20) cyc();
        chk("sat_cnt", {28'b0, stall_cnt_o}, 32'd15);
        cnt_clr_i = 1'b1;
        cyc();
        chk("clr_cnt", {28'b0, stall_cnt_o}, 32'd0);
        cnt_clr_i = 1'b0; out_ready_i = 1'b1;
        cyc();

        // Asynchronous reset with two entries held.
        in_valid_i = 1'b1; in_data_i = 32'h21; out_ready_i = 1'b0;
        cyc();
        in_data_i = 32'h22;
        cyc();
        in_valid_i = 1'b0;
        #2 rst = 1'b0;
        model_step();
        #1;
        chk("arst_valid", {31'b0, out_valid_o}, 32'd0);
        chk("arst_data", out_data_o, 32'h13);
        chk("arst_ready", {31'b0, in_ready_o}, 32'd1);
        chk("arst_cnt", {28'b0, stall_cnt_o}, 32'd0);
        cyc();
        rst = 1'b1;
        cyc();

        // Randomized traffic; the source holds its payload while stalled.
        for (int i = 0; i < 12000; i++) begin
            if (!in_valid_i || in_ready_o) begin
                in_valid_i = ($urandom_range(0, 9) < 6);
                in_data_i  = $urandom;
            end
            out_ready_i = (i % 500 < 40) ? 1'b0 : ($urandom_range(0, 9) < 7);
            flush_i     = ($urandom_range(0, 99) < 3);
            cnt_clr_i   = ($urandom_range(0, 199) < 3);
            cyc();
        end
        in_valid_i = 1'b0; flush_i = 1'b0; cnt_clr_i = 1'b0; out_ready_i = 1'b1;
        cyc(); cyc(); cyc();
        chk("final_empty", {31'b0, out_valid_o}, 32'd0);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
